// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step/run clock controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam int unsigned RATE_SHIFT0 = 0;
    localparam int unsigned RATE_SHIFT1 = 2;
    localparam int unsigned RATE_SHIFT2 = 4;
    localparam int unsigned RATE_SHIFT3 = 6;

    // Auto-run divisor is TC_BASE >> rate_shift(rate_sel).
    function automatic int unsigned rate_shift(input logic [1:0] rate);
        int unsigned sh;
        case (rate)
            2'd0:    sh = RATE_SHIFT0;
            2'd1:    sh = RATE_SHIFT1;
            2'd2:    sh = RATE_SHIFT2;
            default: sh = RATE_SHIFT3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/step_ctrl_edge_det.sv
// Registered rising-edge detector; the previous sample resets high so a level
// already asserted when reset releases does not register as an edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/step_ctrl.sv
// Single-step / auto-run pipeline advance controller with halt support.
// step_pulse is registered: it appears one cycle after the deciding clock edge.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int TC_BASE = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_mode,
    input  logic [1:0]  rate_sel,
    input  logic        halt_in,
    input  logic        clr_count,
    output logic        step_pulse,
    output logic [1:0]  state_out,
    output logic [15:0] step_count
);

    localparam int PW = (TC_BASE > 1) ? $clog2(TC_BASE) : 1;

    // Terminal prescaler value for a rate; divisors below one clamp to a pulse every cycle.
    function automatic logic [PW-1:0] tc_last(input logic [1:0] rate);
        int t;
        t = TC_BASE >> rate_shift(rate);
        if (t < 1) begin
            t = 1;
        end
        return PW'(t - 1);
    endfunction

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    rate_q;
    logic          pulse_nxt;
    logic [15:0]   count_nxt;
    logic          step_rise, mode_rise;

    edge_det u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_step),
        .rise  (step_rise)
    );

    edge_det u_mode_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_mode),
        .rise  (mode_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_STEP;
            presc      <= '0;
            rate_q     <= 2'd0;
            step_pulse <= 1'b0;
            step_count <= 16'd0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            rate_q     <= rate_sel;
            step_pulse <= pulse_nxt;
            step_count <= count_nxt;
        end
    end

    // Priority in RUN: halt, then mode toggle, then rate change, then terminal count.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        pulse_nxt = 1'b0;
        case (state)
            ST_STEP: begin
                if (mode_rise) begin
                    state_nxt = ST_RUN;
                    presc_nxt = '0;
                end else if (step_rise) begin
                    pulse_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_in) begin
                    state_nxt = ST_HALTED;
                end else if (mode_rise) begin
                    state_nxt = ST_STEP;
                end else if (rate_sel != rate_q) begin
                    presc_nxt = '0;
                end else if (presc >= tc_last(rate_q)) begin
                    pulse_nxt = 1'b1;
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            ST_HALTED: begin
                if (mode_rise) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_STEP;
        endcase
    end

    always_comb begin
        count_nxt = step_count;
        if (clr_count) begin
            count_nxt = 16'd0;
        end else if (pulse_nxt) begin
            count_nxt = step_count + 16'd1;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized and directed bench for step_ctrl against a cycle-level reference model.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step, btn_mode, halt_in, clr_count;
    logic [1:0]  rate_sel;
    logic        step_pulse;
    logic [1:0]  state_out;
    logic [15:0] step_count;

    int errors = 0;
    int checks = 0;

    step_ctrl #(.TC_BASE(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_mode   (btn_mode),
        .rate_sel   (rate_sel),
        .halt_in    (halt_in),
        .clr_count  (clr_count),
        .step_pulse (step_pulse),
        .state_out  (state_out),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Reference: mode 0=step 1=run 2=halted; elapsed = cycles since the run timer restarted.
    int m_mode, m_elapsed, m_count, m_rate;
    bit m_pulse, m_pstep, m_pmode;

    function automatic int tc_of(input int r);
        int t;
        t = 64 / (4 ** r);
        return (t < 1) ? 1 : t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_count = 0; m_rate = 0;
        m_pulse = 0; m_pstep = 1; m_pmode = 1;
    endtask

    task automatic model_step(input bit s, input bit m, input int r, input bit h, input bit c);
        bit se, me, p;
        se = s && !m_pstep;
        me = m && !m_pmode;
        p = 0;
        if (m_mode == 0) begin
            if (me) begin m_mode = 1; m_elapsed = 0; end
            else if (se) p = 1;
        end else if (m_mode == 1) begin
            if (h) m_mode = 2;
            else if (me) m_mode = 0;
            else if (r != m_rate) m_elapsed = 0;
            else begin
                m_elapsed++;
                if (m_elapsed % tc_of(r) == 0) p = 1;
            end
        end else begin
            if (me) m_mode = 0;
        end
        m_pulse = p;
        if (c) m_count = 0;
        else if (p) m_count = (m_count + 1) % 65536;
        m_rate = r;
        m_pstep = s;
        m_pmode = m;
    endtask

    task automatic tick(input bit s, input bit m, input int r, input bit h, input bit c);
        @(negedge clk);
        btn_step = s; btn_mode = m; rate_sel = 2'(r); halt_in = h; clr_count = c;
        model_step(s, m, r, h, c);
        @(posedge clk);
        #1;
        chk("pulse", 32'(step_pulse), 32'(m_pulse));
        chk("state", 32'(state_out), 32'(m_mode));
        chk("count", 32'(step_count), 32'(m_count));
    endtask

    initial begin
        rst = 1'b1; btn_step = 1'b1; btn_mode = 1'b0; rate_sel = 2'd0;
        halt_in = 1'b0; clr_count = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Button held through reset release must not step.
        repeat (3) tick(1, 0, 0, 0, 0);
        chk("held_btn_count", 32'(step_count), 32'd0);

        // Three single-step presses.
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            tick(1, 0, 0, 0, 0);
            tick(1, 0, 0, 0, 0);
        end
        chk("three_steps", 32'(step_count), 32'd3);

        // Auto-run at TC=4 for ten pulses.
        tick(0, 0, 2, 0, 1);
        tick(0, 0, 2, 0, 0);
        tick(0, 1, 2, 0, 0);
        chk("run_entry", 32'(state_out), 32'd1);
        for (int i = 0; i < 40; i++) tick(0, 1, 2, 0, 0);
        chk("ten_pulses", 32'(step_count), 32'd10);

        // TC=1 runs every cycle, then halt freezes and mode returns to step.
        tick(0, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 3, 0, 0);
        chk("tc1_pulse", 32'(step_pulse), 32'd1);
        tick(0, 1, 3, 1, 0);
        chk("halt_state", 32'(state_out), 32'd2);
        chk("halt_no_pulse", 32'(step_pulse), 32'd0);
        for (int i = 0; i < 4; i++) tick(1, 1, 3, 1, 0);
        tick(0, 0, 3, 1, 0);
        tick(0, 1, 3, 1, 0);
        chk("halt_to_step", 32'(state_out), 32'd0);

        // Mode edge on the terminal-count cycle wins over the pulse.
        tick(0, 0, 2, 0, 0);
        tick(0, 1, 2, 0, 0);
        begin
            int guard = 0;
            while ((m_elapsed % 4) != 3 && guard < 10) begin
                tick(0, 0, 2, 0, 0);
                guard++;
            end
            chk("tc_align_guard", 32'(guard < 10), 32'd1);
        end
        tick(0, 1, 2, 0, 0);
        chk("mode_vs_tc_pulse", 32'(step_pulse), 32'd0);
        chk("mode_vs_tc_state", 32'(state_out), 32'd0);

        // Asynchronous reset while a pulse is being driven.
        tick(0, 0, 3, 0, 0);
        tick(0, 1, 3, 0, 0);
        tick(0, 1, 3, 0, 0);
        chk("pre_rst_pulse", 32'(step_pulse), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_pulse", 32'(step_pulse), 32'd0);
        chk("async_rst_state", 32'(state_out), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;

        // Counter wrap at 0xFFFF and clear winning over a pulse.
        tick(0, 0, 3, 0, 1);
        tick(0, 1, 3, 0, 0);
        for (int i = 0; i < 65535; i++) tick(0, 1, 3, 0, 0);
        chk("count_ffff", 32'(step_count), 32'h0000_ffff);
        tick(0, 1, 3, 0, 0);
        chk("count_wrap", 32'(step_count), 32'd0);
        tick(0, 1, 3, 0, 1);
        chk("clr_vs_pulse", 32'(step_count), 32'd0);
        chk("clr_pulse_still", 32'(step_pulse), 32'd1);

        // Random mix of all inputs.
        begin
            bit s, m, h, c;
            int r;
            s = 0; m = 1; h = 0; r = 3;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) s = ~s;
                if ($urandom_range(0, 15) == 0) m = ~m;
                if ($urandom_range(0, 40) == 0) r = int'($urandom_range(0, 3));
                if ($urandom_range(0, 30) == 0) h = ~h;
                c = ($urandom_range(0, 60) == 0);
                tick(s, m, r, h, c);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
